// File: rtl/gpio_pkg.sv
// Shared GPIO constants for the switch conditioner, cpu and top.
// Also holds the counter width helper for the debouncer.
package gpio_pkg;

    localparam int GPIO_IN_W        = 18;
    localparam int DEBOUNCE_DEFAULT = 500000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch lane: two-flop synchronizer, saturating run counter,
// debounced level flop and registered rise/fall pulses.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic res,
    input  logic sw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Bring the raw switch into the clock domain.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has persisted long enough.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    // Counter, debounced level and edge pulses.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign evt_o    = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Board switch conditioner: WIDTH independent debounce lanes plus a
// single any-change pulse aligned with the per-bit edge pulses.
module sw_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_IN_W,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] evt;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .res     (res),
            .sw_i    (sw_raw[i]),
            .stable_o(sw_stable[i]),
            .rise_o  (sw_rise[i]),
            .fall_o  (sw_fall[i]),
            .evt_o   (evt[i])
        );
    end

    // Register the OR of next-cycle pulses so it lines up with them.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |evt;
        end
    end

    assign sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random switch activity,
// scored against a history-window reference model.
module tb_sw_debounce;

    localparam int W = 18;
    localparam int N = 4;

    typedef struct packed {
        logic [W-1:0] st;
        logic [W-1:0] ri;
        logic [W-1:0] fa;
        logic         ch;
    } exp_t;

    logic         clk = 1'b0;
    logic         res;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int checks   = 0;
    int failures = 0;
    int rise9    = 0;

    exp_t sb[$];

    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    logic [W-1:0] m_st = '0;
    logic [W-1:0] win[$];

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk       (clk),
        .res       (res),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    // Reference: a bit flips once its synchronized value has differed
    // from the reported level on each of the last N edges.
    always @(posedge clk) begin : model
        exp_t         e;
        logic [W-1:0] nst;
        logic         flip;
        e = '0;
        if (!res) begin
            m_s1 = '0;
            m_s2 = '0;
            m_st = '0;
            win.delete();
        end else begin
            win.push_back(m_s2);
            if (win.size() > N) void'(win.pop_front());
            m_s2 = m_s1;
            m_s1 = sw_raw;
            nst  = m_st;
            if (win.size() == N) begin
                for (int i = 0; i < W; i++) begin
                    flip = 1'b1;
                    for (int k = 0; k < N; k++)
                        if (win[k][i] == m_st[i]) flip = 1'b0;
                    if (flip) nst[i] = ~m_st[i];
                end
            end
            e.st = nst;
            e.ri = nst & ~m_st;
            e.fa = ~nst & m_st;
            e.ch = |(e.ri | e.fa);
            m_st = nst;
        end
        sb.push_back(e);
    end

    // Monitor: compare every cycle's outputs against the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({sw_stable, sw_rise, sw_fall, sw_changed} !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got st=%h ri=%h fa=%h ch=%b want st=%h ri=%h fa=%h ch=%b",
                         $time, sw_stable, sw_rise, sw_fall, sw_changed,
                         e.st, e.ri, e.fa, e.ch);
            end
        end
    end

    always @(negedge clk) if (sw_rise[9] === 1'b1) rise9++;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic check_clear(input string nm);
        checks++;
        if ({sw_stable, sw_rise, sw_fall, sw_changed} !== '0) begin
            failures++;
            $display("FAIL %s got st=%h ri=%h fa=%h ch=%b want all zero",
                     nm, sw_stable, sw_rise, sw_fall, sw_changed);
        end
    endtask

    task automatic wait_stable(input int b, input logic v, input int exp);
        int k;
        k = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (sw_stable[b] === v) begin
                k = j;
                break;
            end
        end
        checks++;
        if (k != exp) begin
            failures++;
            $display("FAIL latency bit%0d got edge=%0d want edge=%0d (0=timeout)",
                     b, k, exp);
        end
        #2;
    endtask

    initial begin
        int idx;
        res    = 1'b0;
        sw_raw = '1;
        repeat (2) @(negedge clk);
        #2;
        check_clear("reset_hold");
        step(2);
        check_clear("reset_hold2");
        sw_raw = '0;
        step(1);
        res = 1'b1;
        step(8);

        sw_raw[0] = 1'b1;
        wait_stable(0, 1'b1, 6);
        step(4);

        sw_raw[3] = 1'b1;
        step(3);
        sw_raw[3] = 1'b0;
        step(8);
        checks++;
        if (sw_stable[3] !== 1'b0) begin
            failures++;
            $display("FAIL glitch got=%b want=0", sw_stable[3]);
        end

        sw_raw[5] = 1'b1;
        wait_stable(5, 1'b1, 6);
        step(3);
        sw_raw[17] = 1'b1;
        sw_raw[5]  = 1'b0;
        wait_stable(17, 1'b1, 6);
        checks++;
        if (sw_rise !== 18'h20000 || sw_fall !== 18'h00020 || sw_changed !== 1'b1) begin
            failures++;
            $display("FAIL simul got ri=%h fa=%h ch=%b want ri=20000 fa=00020 ch=1",
                     sw_rise, sw_fall, sw_changed);
        end
        step(4);

        sw_raw[2] = 1'b1;
        step(3);
        res = 1'b0;
        #1;
        check_clear("reset_mid");
        step(2);
        res = 1'b1;
        wait_stable(2, 1'b1, 6);
        step(4);

        rise9 = 0;
        for (int i = 0; i < 10; i++) begin
            sw_raw[9] = i[0];
            if (i < 9) step(2);
        end
        wait_stable(9, 1'b1, 6);
        step(3);
        checks++;
        if (rise9 != 1) begin
            failures++;
            $display("FAIL bounce_rises got=%0d want=1", rise9);
        end

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, W - 1);
                sw_raw[idx] = ~sw_raw[idx];
            end
            if ($urandom_range(0, 149) == 0) begin
                res = 1'b0;
                #1;
                check_clear("rand_reset");
                step(1);
                res = 1'b1;
            end
            step(1);
        end

        step(3);
        for (int t = 0; t < 10 && sb.size() > 0; t++) step(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, giving the number of switch inputs conditioned.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), legal range 1 to 2^24-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port res, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sw_raw, input, WIDTH bits: unsynchronized board switches (SW).
REQ-006 The block SHALL have port sw_stable, output, WIDTH bits: debounced switch levels, driving the cpu gpio_in port.
REQ-007 The block SHALL have port sw_rise, output, WIDTH bits: one-cycle pulse per bit on a debounced 0->1 change.
REQ-008 The block SHALL have port sw_fall, output, WIDTH bits: one-cycle pulse per bit on a debounced 1->0 change.
REQ-009 The block SHALL have port sw_changed, output, 1 bit: one-cycle pulse, high when any bit of sw_rise or sw_fall is high.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2); no other logic SHALL read sw_raw or sync1.
REQ-011 Each bit SHALL own an independent counter of width clog2(DEBOUNCE_CYCLES)+1 bits.
REQ-012 On each edge where sync2 differs from sw_stable: if cnt equals DEBOUNCE_CYCLES-1, sw_stable SHALL take sync2 and cnt SHALL clear to 0; otherwise cnt SHALL increment.
REQ-013 On each edge where sync2 equals sw_stable, cnt SHALL clear to 0; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles therefore produces no output change.
REQ-014 Latency: for a raw change held steady that first settles before edge 1, sw_stable SHALL update on edge DEBOUNCE_CYCLES+2; with DEBOUNCE_CYCLES=1 this is synchronizer delay plus one edge.
REQ-015 sw_rise[i] and sw_fall[i] SHALL be registered and high for exactly the one cycle in which sw_stable[i] holds its new value for the first time.
REQ-016 sw_changed SHALL be registered, asserting in the same cycle as the corresponding rise/fall pulses.
REQ-017 Simultaneous qualifying changes on several bits SHALL update those bits together, with a single sw_changed cycle.
REQ-018 cnt SHALL never wrap, and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-019 Bits SHALL be fully independent; activity on one bit SHALL NOT alter the counter of another.

Reset
REQ-020 While res is low, sync1, sync2, sw_stable, sw_rise, sw_fall, sw_changed and every counter SHALL be 0, regardless of clk.
REQ-021 Reset asserted mid-count SHALL discard the count; after release, a full REQ-014 interval SHALL be required before any change is reported.
REQ-022 Switches already high at reset release SHALL be reported as a normal rise after the REQ-014 interval.

Structure
REQ-023 Shared package gpio_pkg SHALL hold the constants GPIO_IN_W (18) and DEBOUNCE_DEFAULT (500000), used by sw_debounce, cpu and top.
REQ-024 The per-bit logic (synchronizer, counter, stable flop, edge pulses) SHALL be the sub-module debounce_bit, instantiated WIDTH times.
REQ-025 sw_debounce SHALL contain only the instance array and the sw_changed OR-reduction register.

Verification (DEBOUNCE_CYCLES=4, WIDTH=18)
REQ-026 Reset test: with res low and sw_raw=18'h3FFFF, all outputs SHALL read 0.
REQ-027 Clean-rise test: after reset, SW[0] goes 0->1 before edge 1 and is held; sw_stable[0] SHALL rise on edge 6, and sw_rise[0] and sw_changed SHALL be high for exactly one cycle.
REQ-028 Glitch test: SW[3] is high for 3 cycles, then low; sw_stable[3], sw_rise and sw_changed SHALL remain 0.
REQ-029 Simultaneous test: with SW[5]=1 stable, SW[17] goes 0->1 and SW[5] goes 1->0 in the same cycle; both SHALL update on the same edge, sw_rise=18'h20000 and sw_fall=18'h00020 together, with one sw_changed pulse.
REQ-030 Reset-mid-count test: SW[2] goes high and res is pulsed low after 3 edges; outputs SHALL clear immediately, and after release sw_stable[2] SHALL rise exactly 6 edges later.
REQ-031 Bounce test: SW[9] toggles every 2 cycles for 20 cycles, then holds 1; exactly one sw_rise[9] pulse SHALL occur, 6 edges after the last toggle.
